// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: serialises address/command into a 38 kHz-modulated frame; envelope rises one clock after start.
// Define IR_TX_REPEAT_EN to send NEC repeat codes while start stays high instead of back-to-back full frames.
module nec_ir_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int FRAME_UNITS  = 192
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] address,
  input  logic [7:0] command,
  output logic       busy,
  output logic       done,
  output logic       ir_envelope,
  output logic       ir_tx
);

  localparam int CW = $clog2(UNIT_CYCLES);
  localparam int PW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam int FW = $clog2(FRAME_UNITS + 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(UNIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(CARRIER_HALF - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_UNITS - 1);

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
`ifdef IR_TX_REPEAT_EN
    , REP_MARK, REP_SPACE, REP_STOP, REP_GAP
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cyc_cnt;
  logic [7:0]      unit_cnt;
  logic [FW-1:0]   frame_cnt;
  logic [31:0]     shreg;
  logic [4:0]      bit_idx;
  logic [PW-1:0]   ph_cnt, ph_cnt_nxt;
  logic            phase, phase_nxt;
  logic [7:0]      unit_len;
  logic            unit_tick, unit_done, frame_done, frame_clr;
  logic            env_nxt, busy_nxt, done_nxt, tx_nxt;

  assign unit_tick  = (cyc_cnt == CYC_LAST);
  assign frame_done = unit_tick && (frame_cnt == FRAME_LAST);
  assign unit_done  = unit_tick && (unit_cnt == unit_len - 8'd1);

  always_comb begin
    unit_len = 8'd1;
    case (state)
      LEAD_MARK:  unit_len = 8'd16;
      LEAD_SPACE: unit_len = 8'd8;
      BIT_SPACE:  unit_len = shreg[0] ? 8'd3 : 8'd1;
`ifdef IR_TX_REPEAT_EN
      REP_MARK:   unit_len = 8'd16;
      REP_SPACE:  unit_len = 8'd4;
`endif
      default:    unit_len = 8'd1;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start)     state_nxt = LEAD_MARK;
      LEAD_MARK:  if (unit_done) state_nxt = LEAD_SPACE;
      LEAD_SPACE: if (unit_done) state_nxt = BIT_MARK;
      BIT_MARK:   if (unit_done) state_nxt = BIT_SPACE;
      BIT_SPACE:  if (unit_done) state_nxt = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (unit_done) state_nxt = GAP;
`ifdef IR_TX_REPEAT_EN
      GAP:        if (frame_done) state_nxt = start ? REP_MARK : IDLE;
      REP_MARK:   if (unit_done)  state_nxt = REP_SPACE;
      REP_SPACE:  if (unit_done)  state_nxt = REP_STOP;
      REP_STOP:   if (unit_done)  state_nxt = REP_GAP;
      REP_GAP:    if (frame_done) state_nxt = start ? REP_MARK : IDLE;
`else
      GAP:        if (frame_done) state_nxt = IDLE;
`endif
      default:    state_nxt = IDLE;
    endcase
  end

  // Output values are computed from the next state so every output leaves a flop.
  always_comb begin
    env_nxt  = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) || (state_nxt == STOP_MARK);
    done_nxt = (state == GAP) && frame_done;
`ifdef IR_TX_REPEAT_EN
    env_nxt  = env_nxt || (state_nxt == REP_MARK) || (state_nxt == REP_STOP);
    done_nxt = done_nxt || ((state == REP_GAP) && frame_done);
`endif
    busy_nxt = (state_nxt != IDLE);
    ph_cnt_nxt = ph_cnt;
    phase_nxt  = phase;
    if (!env_nxt || !ir_envelope) begin
      ph_cnt_nxt = '0;
      phase_nxt  = 1'b1;
    end else if (ph_cnt == PH_LAST) begin
      ph_cnt_nxt = '0;
      phase_nxt  = ~phase;
    end else begin
      ph_cnt_nxt = ph_cnt + 1'b1;
    end
    tx_nxt = env_nxt & phase_nxt;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      ir_envelope <= 1'b0;
      ir_tx       <= 1'b0;
      ph_cnt      <= '0;
      phase       <= 1'b1;
    end else begin
      busy        <= busy_nxt;
      done        <= done_nxt;
      ir_envelope <= env_nxt;
      ir_tx       <= tx_nxt;
      ph_cnt      <= ph_cnt_nxt;
      phase       <= phase_nxt;
    end
  end

  // Frame counter restarts on every frame or repeat-code entry; gaps end on it.
  always_comb begin
    frame_clr = (state_nxt == IDLE);
`ifdef IR_TX_REPEAT_EN
    frame_clr = frame_clr || ((state_nxt == REP_MARK) && (state != REP_MARK));
`endif
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      cyc_cnt   <= '0;
      unit_cnt  <= '0;
      frame_cnt <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
    end else begin
      cyc_cnt <= (state == IDLE || unit_tick) ? '0 : cyc_cnt + 1'b1;
      if (state_nxt != state) unit_cnt <= '0;
      else if (unit_tick)     unit_cnt <= unit_cnt + 8'd1;
      if (frame_clr)          frame_cnt <= '0;
      else if (unit_tick)     frame_cnt <= frame_cnt + 1'b1;
      if (state == IDLE && start) begin
        shreg   <= {~command, command, ~address, address};
        bit_idx <= '0;
      end else if (state == BIT_SPACE && unit_done) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed bench for nec_ir_transmitter: table of frames plus reset, mid-frame reset and held-start sequences.
module tb_nec_ir_transmitter;
  localparam int UNIT      = 8;
  localparam int HALF      = 2;
  localparam int FRAME     = 192;
  localparam int FRAME_CYC = UNIT * FRAME;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] command = 8'h00;
  logic       busy, done, ir_envelope, ir_tx;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  cmd;
    logic [31:0] word;
  } vec_t;
  vec_t vecs [3];

  nec_ir_transmitter #(
    .UNIT_CYCLES(UNIT),
    .CARRIER_HALF(HALF),
    .FRAME_UNITS(FRAME)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .start(start),
    .address(address),
    .command(command),
    .busy(busy),
    .done(done),
    .ir_envelope(ir_envelope),
    .ir_tx(ir_tx)
  );

  always #5 clk_50 = ~clk_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  // Starts at the first envelope-high cycle, returns at the cycle done is seen.
  task automatic capture_frame(input logic busy_at_done, output logic [31:0] word,
                               output int marks, output int lead, output int lsp,
                               output int done_at, output int tx_err, output int busy_err);
    int   run, spc, mpos;
    logic prev, exp_tx;
    word = '0; marks = 0; lead = -1; lsp = -1; done_at = -1; tx_err = 0; busy_err = 0;
    run = 0; spc = 0; mpos = 0; prev = 1'b0;
    for (int n = 0; n < FRAME_CYC + 64; n++) begin
      if (done === 1'b1) begin
        done_at = n;
        if (busy !== busy_at_done) busy_err++;
        break;
      end
      if (busy !== 1'b1) busy_err++;
      if (ir_envelope && !prev) begin
        if (spc == 1) lsp = run;
        else if (spc >= 2 && spc <= 33) word[spc-2] = (run >= 2 * UNIT);
        marks++;
        run  = 0;
        mpos = 0;
      end else if (!ir_envelope && prev) begin
        if (marks == 1) lead = run;
        spc++;
        run = 0;
      end
      exp_tx = ir_envelope && ((mpos % (2 * HALF)) < HALF);
      if (ir_tx !== exp_tx) tx_err++;
      if (ir_envelope) mpos++;
      run++;
      prev = ir_envelope;
      tick();
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp_word,
                             input logic busy_at_done, output int done_at);
    logic [31:0] word;
    int marks, lead, lsp, tx_err, busy_err;
    capture_frame(busy_at_done, word, marks, lead, lsp, done_at, tx_err, busy_err);
    check({tag, "_word"}, word, exp_word);
    check({tag, "_marks"}, marks, 34);
    check({tag, "_lead_mark"}, lead, 16 * UNIT);
    check({tag, "_lead_space"}, lsp, 8 * UNIT);
    check({tag, "_done_at"}, done_at, FRAME_CYC);
    check({tag, "_carrier"}, tx_err, 0);
    check({tag, "_busy"}, busy_err, 0);
  endtask

  initial begin
    int d1, d2, err;
    vecs[0] = '{8'h00, 8'h45, 32'hBA45FF00};
    vecs[1] = '{8'hA5, 8'h3C, 32'hC33C5AA5};
    vecs[2] = '{8'h12, 8'h16, 32'hE916ED12};

    // Reset held with start high: outputs quiet, frame starts right after release.
    reset = 1'b1; start = 1'b1; address = 8'h00; command = 8'h45;
    err = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({busy, done, ir_envelope, ir_tx} !== 4'b0000) err++;
    end
    check("reset_outputs", err, 0);
    reset = 1'b0;
    tick();
    check("start_after_reset", ir_envelope, 1);
    start = 1'b0;
    check_frame("rst_frame", 32'hBA45FF00, 1'b0, d1);
    tick();

    for (int v = 0; v < 3; v++) begin
      address = vecs[v].addr;
      command = vecs[v].cmd;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_frame($sformatf("vec%0d", v), vecs[v].word, 1'b0, d1);
      tick();
      check($sformatf("vec%0d_done_width", v), done, 0);
    end

    // Reset during the bit-10 mark of 0xA5/0x3C (cycles 432..439).
    address = 8'hA5; command = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (435) tick();
    check("bit10_mark", ir_envelope, 1);
    reset = 1'b1;
    tick();
    check("midreset_outputs", {busy, done, ir_envelope, ir_tx}, 0);
    reset = 1'b0;
    err = 0;
    for (int i = 0; i < FRAME_CYC + 64; i++) begin
      tick();
      if (done || busy || ir_envelope || ir_tx) err++;
    end
    check("midreset_quiet", err, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame("post_reset", 32'hC33C5AA5, 1'b0, d1);
    tick();

`ifndef IR_TX_REPEAT_EN
    // Held start: back-to-back frames, second latches the command changed mid-frame.
    address = 8'h00; command = 8'h45; start = 1'b1;
    tick();
    command = 8'h16;
    check_frame("held1", 32'hBA45FF00, 1'b0, d1);
    check("held_no_overlap", ir_envelope, 0);
    tick();
    start = 1'b0;
    check_frame("held2", 32'hE916FF00, 1'b0, d2);
    check("held_second_done_abs", d1 + 1 + d2, 2 * FRAME_CYC + 1);
    tick();
`else
    begin : repeat_seq
      int runs [4];
      int ri, run, dn, berr;
      logic prev;
      address = 8'h00; command = 8'h45; start = 1'b1;
      tick();
      check_frame("rep_frame", 32'hBA45FF00, 1'b1, d1);
      check("rep_mark_start", ir_envelope, 1);
      for (int k = 0; k < 4; k++) runs[k] = -1;
      ri = 0; run = 0; dn = -1; berr = 0; prev = 1'b1;
      for (int n = 0; n < FRAME_CYC + 64; n++) begin
        if (n > 0 && done === 1'b1) begin
          dn = n;
          break;
        end
        if (busy !== 1'b1) berr++;
        if (n > 0 && ir_envelope !== prev) begin
          if (ri < 4) runs[ri] = run;
          ri++;
          run = 0;
        end
        run++;
        prev = ir_envelope;
        if (n == 400) start = 1'b0;
        tick();
      end
      check("rep_mark", runs[0], 16 * UNIT);
      check("rep_space", runs[1], 4 * UNIT);
      check("rep_stop", runs[2], UNIT);
      check("rep_done_at", dn, FRAME_CYC);
      check("rep_busy", berr, 0);
      check("rep_end_busy", busy, 0);
      tick();
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
